multiple_n_tx: RTL

Serial transmitter that is the sending end of the divisible-by-N serial link. It accepts a W-bit multiplier `m`, forms the product m×N with a sequential shift-add multiplier, and shifts it out MSB-first on a single-bit line, one bit per clock. A divisible-by-N checker on the far end sees a residue of 0 after the last bit. An internal residue tracker mirrors that checker and flags `div_ok` as a built-in self-check.

---
 rtl/multiple_n_tx.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/multiple_n_tx.sv
// -----------------------------------------------------------------------------
// multiple_n_tx
//
// Sending end of the divisible-by-N serial link. A W-bit multiplier m is
// captured on an accepted start, multiplied by the constant N using a
// sequential shift-add multiplier (one multiplier bit per clock), and the
// P = W+NW bit product is shifted out MSB-first, one bit per clock. Because
// the frame is an exact multiple of N, a divisible-by-N checker on the far
// end ends each frame with residue 0. An internal residue tracker mirrors
// that checker and reports the outcome on div_ok as a built-in self-check.
//
// Parameters:
//   N   constant multiplicand / divisor, 1 <= N < 2**NW
//   NW  bit width of N
//   W   multiplier width
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset (wins over start)
//   start      in   frame request, sampled only while ready=1
//   m          in   multiplier, captured on the accepted start
//   ready      out  high while idle; a new frame may be requested
//   out        out  serial data, MSB first; 0 when out_valid=0
//   out_valid  out  high for exactly P consecutive cycles per frame
//   last       out  high with the final (LSB) bit of the frame
//   done       out  one-cycle pulse after the last bit
//   div_ok     out  residue self-check result of the most recent frame
//
// Frame timing (accept at edge t0): MUL on edges t0+1..t0+W, bits on edges
// t0+W+1..t0+W+P, done/div_ok on edge t0+W+P+1, next accept at t0+W+P+2.
// All outputs are registered.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | ready=1, waiting for start
// MUL    | W shift-add steps building m*N in the accumulator
// SEND   | P serial bits from the shift register, residue tracked
// DONE   | done pulse, div_ok updated, back to IDLE
// -----------------------------------------------------------------------------
module multiple_n_tx #(
  parameter int N  = 5,
  parameter int NW = 3,
  parameter int W  = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] m,
  output logic         ready,
  output logic         out,
  output logic         out_valid,
  output logic         last,
  output logic         done,
  output logic         div_ok
);

  localparam int P  = W + NW;
  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam int CW = (P > 1) ? $clog2(P) : 1;

  localparam logic [P-1:0]  N_P      = P'(N);
  localparam logic [NW:0]   N_R      = (NW + 1)'(N);
  localparam logic [IW-1:0] IDX_LAST = IW'(W - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(P - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_SEND,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [W-1:0]  mplier_q;
  logic [P-1:0]  acc_q;
  logic [IW-1:0] idx_q;
  logic [P-1:0]  shift_q;
  logic [CW-1:0] cnt_q;
  logic [NW-1:0] res_q;

  logic ready_q;
  logic out_q;
  logic out_valid_q;
  logic last_q;
  logic done_q;
  logic div_ok_q;

  logic [P-1:0]  addend_d;
  logic [P-1:0]  acc_d;
  logic [NW:0]   res_dbl_d;
  logic [NW-1:0] res_d;

  // Shift-add step and the residue update for the bit currently at the
  // head of the shift register. Since r < N, 2r+bit < 2N, so a single
  // conditional subtract of N is enough to reduce it back below N.
  always_comb begin
    addend_d  = mplier_q[0] ? (N_P << idx_q) : '0;
    acc_d     = acc_q + addend_d;
    res_dbl_d = {res_q, shift_q[P-1]};
    if (res_dbl_d >= N_R) begin
      res_d = NW'(res_dbl_d - N_R);
    end else begin
      res_d = res_dbl_d[NW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mplier_q    <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      ready_q     <= 1'b1;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      div_ok_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ready_q     <= 1'b1;
          out_q       <= 1'b0;
          out_valid_q <= 1'b0;
          last_q      <= 1'b0;
          if (start) begin
            mplier_q <= m;
            acc_q    <= '0;
            res_q    <= '0;
            idx_q    <= '0;
            ready_q  <= 1'b0;
            state_q  <= S_MUL;
          end
        end

        S_MUL: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q >> 1;
          idx_q    <= idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            // Load the finished product directly from the adder so SEND
            // starts on the very next edge.
            shift_q <= acc_d;
            cnt_q   <= '0;
            state_q <= S_SEND;
          end
        end

        S_SEND: begin
          out_q       <= shift_q[P-1];
          out_valid_q <= 1'b1;
          last_q      <= (cnt_q == CNT_LAST);
          shift_q     <= shift_q << 1;
          res_q       <= res_d;
          cnt_q       <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q <= S_DONE;
          end
        end

        S_DONE: begin
          out_q       <= 1'b0;
          out_valid_q <= 1'b0;
          last_q      <= 1'b0;
          done_q      <= 1'b1;
          div_ok_q    <= (res_q == '0);
          // ready goes high here so a held start is taken on the next edge.
          ready_q     <= 1'b1;
          state_q     <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready     = ready_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign last      = last_q;
  assign done      = done_q;
  assign div_ok    = div_ok_q;

endmodule
